// File: rtl/key_debounce_pulse.sv
// Panel button conditioner: two-FF synchroniser, tick-sampled debounce and
// per-button press/release/auto-repeat pulse generation in the clk domain.
module key_debounce_pulse #(
    parameter int               N_BTN        = 5,
    parameter int               TICK_DIV     = 2000000,
    parameter int               STABLE_CNT   = 2,
    parameter int               REPEAT_DELAY = 25,
    parameter int               REPEAT_RATE  = 5,
    parameter logic [N_BTN-1:0] REPEAT_MASK  = 5'b00001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_input,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_hold
);

    localparam int TW   = $clog2(TICK_DIV);
    localparam int SW   = $clog2(STABLE_CNT + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CNT - 1);
    localparam logic [RW-1:0] DELAY_V   = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] RATE_V    = RW'(REPEAT_RATE);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESSED = 2'd1,
        S_REPEAT  = 2'd2
    } state_t;

    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;
    logic [TW-1:0]    r_tick_cnt;
    logic             w_tick;
    logic [N_BTN-1:0] r_level;
    logic [N_BTN-1:0] r_level_q;
    logic [SW-1:0]    r_stab [N_BTN];
    logic [RW-1:0]    r_rcnt [N_BTN];
    state_t           r_state [N_BTN];
    logic [N_BTN-1:0] r_press;
    logic [N_BTN-1:0] r_release;
    logic [N_BTN-1:0] r_hold;
    logic [N_BTN-1:0] w_rise;
    logic [N_BTN-1:0] w_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn_input;
            r_sync2 <= r_sync1;
        end
    end

    assign w_tick = (r_tick_cnt == TICK_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    // Any tick that sees the synchronised input agree with the level restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_level <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                r_stab[i] <= '0;
            end
        end else if (w_tick) begin
            for (int i = 0; i < N_BTN; i++) begin
                if (r_sync2[i] != r_level[i]) begin
                    if (r_stab[i] == STAB_LAST) begin
                        r_level[i] <= ~r_level[i];
                        r_stab[i]  <= '0;
                    end else begin
                        r_stab[i] <= r_stab[i] + 1'b1;
                    end
                end else begin
                    r_stab[i] <= '0;
                end
            end
        end
    end

    assign w_rise = r_level & ~r_level_q;
    assign w_fall = ~r_level & r_level_q;

    // Fall is tested before the repeat thresholds, so a release beats a coincident repeat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_level_q <= '0;
            r_press   <= '0;
            r_release <= '0;
            r_hold    <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                r_state[i] <= S_IDLE;
                r_rcnt[i]  <= '0;
            end
        end else begin
            r_level_q <= r_level;
            r_press   <= '0;
            r_release <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                case (r_state[i])
                    S_IDLE: begin
                        if (w_rise[i]) begin
                            r_press[i] <= 1'b1;
                            r_rcnt[i]  <= '0;
                            r_state[i] <= S_PRESSED;
                        end
                    end
                    S_PRESSED, S_REPEAT: begin
                        if (w_fall[i]) begin
                            r_release[i] <= 1'b1;
                            r_hold[i]    <= 1'b0;
                            r_rcnt[i]    <= '0;
                            r_state[i]   <= S_IDLE;
                        end else if ((r_state[i] == S_PRESSED) && REPEAT_MASK[i] &&
                                     (r_rcnt[i] == DELAY_V)) begin
                            r_press[i] <= 1'b1;
                            r_hold[i]  <= 1'b1;
                            r_rcnt[i]  <= '0;
                            r_state[i] <= S_REPEAT;
                        end else if ((r_state[i] == S_REPEAT) && (r_rcnt[i] == RATE_V)) begin
                            r_press[i] <= 1'b1;
                            r_rcnt[i]  <= '0;
                        end else if (w_tick && (r_rcnt[i] != '1)) begin
                            r_rcnt[i] <= r_rcnt[i] + 1'b1;
                        end
                    end
                    default: begin
                        r_state[i] <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign btn_level   = r_level;
    assign btn_press   = r_press;
    assign btn_release = r_release;
    assign btn_hold    = r_hold;

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Directed bench for key_debounce_pulse with small tick/debounce parameters.
module tb_key_debounce_pulse;

    localparam int NB = 5;

    logic          clk;
    logic          rst;
    logic [NB-1:0] btn_in;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;
    logic [NB-1:0] btn_hold;

    key_debounce_pulse #(
        .N_BTN       (5),
        .TICK_DIV    (4),
        .STABLE_CNT  (3),
        .REPEAT_DELAY(5),
        .REPEAT_RATE (2),
        .REPEAT_MASK (5'b00001)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_input  (btn_in),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_hold   (btn_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [NB-1:0] din;
        int            ncyc;
        logic [NB-1:0] exp_level;
        logic [NB-1:0] exp_press;
        logic [NB-1:0] exp_release;
    } vec_t;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int since_rst = 0;
    int viol = 0;
    int press_cnt [NB];
    int rel_cnt [NB];
    int first_press [NB];
    int first_rel [NB];
    logic [NB-1:0] prev_press = '0;
    logic [NB-1:0] prev_rel = '0;
    logic [NB-1:0] prev_level = '0;
    logic [NB-1:0] acc_level = '0;
    logic [NB-1:0] acc_hold = '0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_first();
        for (int i = 0; i < NB; i++) begin
            first_press[i] = -1;
            first_rel[i]   = -1;
        end
        acc_level = '0;
        acc_hold  = '0;
    endtask

    // One clock; outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        if (rst) since_rst = 0;
        else since_rst++;
        cyc++;
        #1;
        for (int i = 0; i < NB; i++) begin
            if (btn_press[i]) begin
                press_cnt[i]++;
                if (first_press[i] < 0) first_press[i] = cyc;
            end
            if (btn_release[i]) begin
                rel_cnt[i]++;
                if (first_rel[i] < 0) first_rel[i] = cyc;
            end
        end
        if ((btn_press & btn_release) != '0) viol++;
        if ((btn_press & prev_press) != '0) viol++;
        if ((btn_release & prev_rel) != '0) viol++;
        // Level may only change in the cycle right after a tick (counter value 3).
        if ((btn_level != prev_level) && (since_rst != 0) && ((since_rst % 4) != 0)) viol++;
        prev_press = btn_press;
        prev_rel   = btn_release;
        prev_level = btn_level;
        acc_level  = acc_level | btn_level;
        acc_hold   = acc_hold | btn_hold;
    endtask

    vec_t vecs [5];
    int   pc [NB];
    int   rc [NB];
    int   row_start;
    int   lat;
    int   q [$];
    int   hold_rise;
    int   rel_cyc;
    int   hold_at_rel;
    int   hold_before;
    int   hb;
    int   bad_diff;
    int   c0;
    int   s0;

    initial begin
        vecs[0] = '{5'b00000, 20, 5'b00000, 5'b00000, 5'b00000};
        vecs[1] = '{5'b00010, 40, 5'b00010, 5'b00010, 5'b00000};
        vecs[2] = '{5'b00000, 40, 5'b00000, 5'b00000, 5'b00010};
        vecs[3] = '{5'b11000, 40, 5'b11000, 5'b11000, 5'b00000};
        vecs[4] = '{5'b00000, 40, 5'b00000, 5'b00000, 5'b11000};

        for (int i = 0; i < NB; i++) begin
            press_cnt[i] = 0;
            rel_cnt[i]   = 0;
        end
        clear_first();
        rst    = 1'b1;
        btn_in = '0;
        repeat (3) step();
        chk("reset_level", int'(btn_level), 0);
        chk("reset_press", int'(btn_press), 0);
        chk("reset_release", int'(btn_release), 0);
        chk("reset_hold", int'(btn_hold), 0);
        rst = 1'b0;

        // Table: clean press/release, simultaneous buttons.
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < NB; i++) begin
                pc[i] = press_cnt[i];
                rc[i] = rel_cnt[i];
            end
            clear_first();
            row_start = cyc;
            btn_in = vecs[v].din;
            repeat (vecs[v].ncyc) step();
            chk($sformatf("row%0d_level", v), int'(btn_level), int'(vecs[v].exp_level));
            chk($sformatf("row%0d_hold_seen", v), int'(acc_hold), 0);
            for (int i = 0; i < NB; i++) begin
                chk($sformatf("row%0d_press_cnt[%0d]", v, i), press_cnt[i] - pc[i],
                    int'(vecs[v].exp_press[i]));
                chk($sformatf("row%0d_release_cnt[%0d]", v, i), rel_cnt[i] - rc[i],
                    int'(vecs[v].exp_release[i]));
                if (vecs[v].exp_press[i]) begin
                    lat = first_press[i] - row_start;
                    chk($sformatf("row%0d_press_latency[%0d]", v, i),
                        int'(lat >= 12 && lat <= 15), 1);
                end
                if (vecs[v].exp_release[i]) begin
                    lat = first_rel[i] - row_start;
                    chk($sformatf("row%0d_release_latency[%0d]", v, i),
                        int'(lat >= 12 && lat <= 15), 1);
                end
            end
            if (vecs[v].exp_press == 5'b11000)
                chk("simul_press_same_cycle", first_press[3], first_press[4]);
            if (vecs[v].exp_release == 5'b11000)
                chk("simul_release_same_cycle", first_rel[3], first_rel[4]);
        end

        // Bounce rejection on button 2.
        pc[2] = press_cnt[2];
        rc[2] = rel_cnt[2];
        clear_first();
        for (int k = 0; k < 12; k++) begin
            btn_in[2] = ~btn_in[2];
            repeat (5) step();
        end
        btn_in[2] = 1'b0;
        repeat (20) step();
        chk("bounce_level_seen", int'(acc_level[2]), 0);
        chk("bounce_press_cnt", press_cnt[2] - pc[2], 0);
        chk("bounce_release_cnt", rel_cnt[2] - rc[2], 0);

        // Tick alignment: sync2 first sees the edge in a tick cycle -> minimum latency 12.
        while ((since_rst % 4) != 1) step();
        btn_in[1] = 1'b1;
        s0 = cyc;
        repeat (10) step();
        chk("align_level_before", int'(btn_level[1]), 0);
        step();
        chk("align_level_rise", int'(btn_level[1]), 1);
        chk("align_press_early", int'(btn_press[1]), 0);
        step();
        chk("align_press_at_12", int'(btn_press[1]), 1);
        chk("align_cycle_count", cyc - s0, 12);
        btn_in[1] = 1'b0;
        repeat (30) step();

        // Auto-repeat on button 0.
        rc[0] = rel_cnt[0];
        clear_first();
        q.delete();
        hold_rise = -1;
        btn_in[0] = 1'b1;
        c0 = cyc;
        for (int k = 0; k < 100; k++) begin
            step();
            if (btn_press[0]) q.push_back(cyc);
            if (btn_hold[0] && hold_rise < 0) hold_rise = cyc;
        end
        btn_in[0] = 1'b0;
        rel_cyc = -1;
        hold_at_rel = -1;
        hold_before = -1;
        for (int k = 0; k < 30 && rel_cyc < 0; k++) begin
            hb = int'(btn_hold[0]);
            step();
            if (btn_press[0]) q.push_back(cyc);
            if (btn_release[0]) begin
                rel_cyc     = cyc;
                hold_at_rel = int'(btn_hold[0]);
                hold_before = hb;
            end
        end
        chk("repeat_enough_presses", int'(q.size() >= 3), 1);
        if (q.size() >= 3) begin
            chk("repeat_first_latency", int'((q[0] - c0) >= 12 && (q[0] - c0) <= 15), 1);
            chk("repeat_first_gap", q[1] - q[0], 20);
            chk("repeat_second_gap", q[2] - q[1], 8);
            chk("repeat_hold_rise", hold_rise, q[1]);
            bad_diff = 0;
            for (int k = 2; k < q.size(); k++)
                if (q[k] - q[k-1] != 8) bad_diff++;
            chk("repeat_gap_all_8", bad_diff, 0);
        end
        chk("repeat_release_seen", int'(rel_cyc >= 0), 1);
        chk("repeat_hold_before_release", hold_before, 1);
        chk("repeat_hold_at_release", hold_at_rel, 0);
        chk("repeat_release_cnt", rel_cnt[0] - rc[0], 1);
        repeat (20) step();

        // Reset while button 0 is in REPEAT.
        btn_in[0] = 1'b1;
        for (int k = 0; k < 60 && !btn_hold[0]; k++) step();
        chk("rstmid_in_repeat", int'(btn_hold[0]), 1);
        repeat (3) step();
        rst = 1'b1;
        step();
        chk("rstmid_level", int'(btn_level), 0);
        chk("rstmid_press", int'(btn_press), 0);
        chk("rstmid_release", int'(btn_release), 0);
        chk("rstmid_hold", int'(btn_hold), 0);
        rst = 1'b0;
        pc[0] = press_cnt[0];
        rc[0] = rel_cnt[0];
        clear_first();
        s0 = cyc;
        repeat (16) step();
        chk("rstmid_press_cnt", press_cnt[0] - pc[0], 1);
        chk("rstmid_press_latency", int'((first_press[0] - s0) > 0 && (first_press[0] - s0) <= 15), 1);
        chk("rstmid_no_release", rel_cnt[0] - rc[0], 0);
        btn_in[0] = 1'b0;
        repeat (30) step();
        chk("rstmid_final_release", rel_cnt[0] - rc[0], 1);

        chk("pulse_and_level_rules", viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
